// File: rtl/uoe_csr_init_master.sv
// Avalon-MM initiator that programs the UOE CSR block at power-up or on request.
// Optional readback verify of each config write: define UOE_CSR_INIT_READBACK_EN.
module uoe_csr_init_master #(
   parameter int ADDR_W      = 13,
   parameter int DATA_W      = 64,
   parameter int CFG_WADDR0  = 'h10,
   parameter int RST_WADDR   = 'h19,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [47:0]       cfg_fpga_mac,
   input  logic [31:0]       cfg_fpga_ip,
   input  logic [15:0]       cfg_fpga_udp_port,
   input  logic [31:0]       cfg_fpga_netmask,
   input  logic [47:0]       cfg_host_mac,
   input  logic [31:0]       cfg_host_ip,
   input  logic [15:0]       cfg_host_udp_port,
   input  logic [15:0]       cfg_payload_per_pkt,
   input  logic [15:0]       cfg_checksum_ip,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_write,
   output logic [DATA_W-1:0] avm_writedata,
   output logic              avm_read,
   input  logic [DATA_W-1:0] avm_readdata,
   input  logic              avm_readdatavalid,
   input  logic              avm_waitrequest,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [3:0]        err_step
);

`ifdef UOE_CSR_INIT_READBACK_EN
   localparam bit RB_EN = 1'b1;
`else
   localparam bit RB_EN = 1'b0;
`endif

   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
   localparam logic [3:0] STEP_ARST = 4'hF;
   localparam logic [3:0] STEP_REL  = 4'd9;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_CMD, S_RD_WAIT, S_FIN, S_DONE, S_ERR
   } state_t;

   state_t            state;
   logic [DATA_W-1:0] cfg_q [9];
   logic [3:0]        step;
   logic [3:0]        nstep;
   logic [TMO_W-1:0]  tmo;
   logic              rd_q;
   logic [ADDR_W-1:0] nxt_addr;
   logic [DATA_W-1:0] nxt_data;
   logic [DATA_W-1:0] cur_cfg;
   logic              fail;

   // Steps 15 and 9 both target the reset-control register.
   function automatic logic [ADDR_W-1:0] byte_addr(input logic [3:0] s);
      int w;
      w = (s == STEP_ARST || s == STEP_REL) ? RST_WADDR
                                            : CFG_WADDR0 + int'(s);
      return ADDR_W'(w << 3);
   endfunction

   always_comb begin
      nstep    = (step == STEP_ARST) ? 4'd0 : step + 4'd1;
      nxt_addr = byte_addr(nstep);
      nxt_data = (nstep < 4'd9) ? cfg_q[nstep] : '0;
      cur_cfg  = (step < 4'd9) ? cfg_q[step] : '0;
      fail     = 1'b0;
      if (state == S_CMD)
         fail = avm_waitrequest && (tmo == TMO_LAST);
      else if (state == S_RD_WAIT)
         fail = avm_readdatavalid ? (avm_readdata != cur_cfg)
                                  : (tmo == TMO_LAST);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state         <= S_IDLE;
         avm_address   <= '0;
         avm_write     <= 1'b0;
         avm_writedata <= '0;
         rd_q          <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
         err_step      <= '0;
         step          <= '0;
         tmo           <= '0;
      end else if (fail) begin
         state     <= S_ERR;
         avm_write <= 1'b0;
         rd_q      <= 1'b0;
         busy      <= 1'b0;
         error     <= 1'b1;
         err_step  <= step;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  cfg_q[0] <= DATA_W'(cfg_fpga_mac);
                  cfg_q[1] <= DATA_W'(cfg_fpga_ip);
                  cfg_q[2] <= DATA_W'(cfg_fpga_udp_port);
                  cfg_q[3] <= DATA_W'(cfg_fpga_netmask);
                  cfg_q[4] <= DATA_W'(cfg_host_mac);
                  cfg_q[5] <= DATA_W'(cfg_host_ip);
                  cfg_q[6] <= DATA_W'(cfg_host_udp_port);
                  cfg_q[7] <= DATA_W'(cfg_payload_per_pkt);
                  cfg_q[8] <= DATA_W'(cfg_checksum_ip);
                  done     <= 1'b0;
                  error    <= 1'b0;
                  err_step <= '0;
                  busy     <= 1'b1;
                  step     <= STEP_ARST;
                  state    <= S_LOAD;
               end
            end
            S_LOAD: begin
               avm_write     <= 1'b1;
               avm_address   <= byte_addr(STEP_ARST);
               avm_writedata <= DATA_W'(64'h6);
               tmo           <= '0;
               state         <= S_CMD;
            end
            S_CMD: begin
               if (!avm_waitrequest) begin
                  tmo <= '0;
                  if (rd_q) begin
                     rd_q  <= 1'b0;
                     state <= S_RD_WAIT;
                  end else if (step == STEP_REL) begin
                     avm_write <= 1'b0;
                     state     <= S_FIN;
                  end else if (RB_EN && step != STEP_ARST) begin
                     avm_write <= 1'b0;
                     rd_q      <= 1'b1;
                  end else begin
                     step          <= nstep;
                     avm_address   <= nxt_addr;
                     avm_writedata <= nxt_data;
                  end
               end else begin
                  tmo <= tmo + 1'b1;
               end
            end
            S_RD_WAIT: begin
               if (avm_readdatavalid) begin
                  avm_write     <= 1'b1;
                  step          <= nstep;
                  avm_address   <= nxt_addr;
                  avm_writedata <= nxt_data;
                  tmo           <= '0;
                  state         <= S_CMD;
               end else begin
                  tmo <= tmo + 1'b1;
               end
            end
            S_FIN: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= S_DONE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef UOE_CSR_INIT_READBACK_EN
   assign avm_read = rd_q;
`else
   assign avm_read = 1'b0;
   logic unused_rb;
   assign unused_rb = ^{rd_q, avm_readdata, avm_readdatavalid};
`endif

endmodule

// File: tb/tb_uoe_csr_init_master.sv
// Scoreboard bench for uoe_csr_init_master: expected writes queued at start,
// a negedge monitor pops and compares every accepted Avalon write.
module tb_uoe_csr_init_master;

`ifdef UOE_CSR_INIT_READBACK_EN
   localparam int LAT0   = 31;
   localparam int STUCK4 = 14;
`else
   localparam int LAT0   = 13;
   localparam int STUCK4 = 6;
`endif
   localparam int TMO = 256;

   typedef struct packed {
      logic [12:0] a;
      logic [63:0] d;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [47:0] fmac, hmac;
   logic [31:0] fip, fmask, hip;
   logic [15:0] fport, hport, payload, csum;
   logic [12:0] avm_address;
   logic        avm_write;
   logic [63:0] avm_writedata;
   logic        avm_read;
   logic [63:0] rdata;
   logic        rdv;
   logic        wr;
   logic        busy, done, error;
   logic [3:0]  err_step;
   logic        corrupt;
   logic [63:0] mem [32];

   int   chk = 0;
   int   err = 0;
   exp_t exp_q[$];
   exp_t mon_e;
   int   lat;

   uoe_csr_init_master dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .start               (start),
      .cfg_fpga_mac        (fmac),
      .cfg_fpga_ip         (fip),
      .cfg_fpga_udp_port   (fport),
      .cfg_fpga_netmask    (fmask),
      .cfg_host_mac        (hmac),
      .cfg_host_ip         (hip),
      .cfg_host_udp_port   (hport),
      .cfg_payload_per_pkt (payload),
      .cfg_checksum_ip     (csum),
      .avm_address         (avm_address),
      .avm_write           (avm_write),
      .avm_writedata       (avm_writedata),
      .avm_read            (avm_read),
      .avm_readdata        (rdata),
      .avm_readdatavalid   (rdv),
      .avm_waitrequest     (wr),
      .busy                (busy),
      .done                (done),
      .error               (error),
      .err_step            (err_step)
   );

   always #5 clk = ~clk;

   // Responder memory with 1-cycle read latency; optional bit-0 corruption on host_ip.
   always @(posedge clk) begin
      if (avm_write && !wr) mem[avm_address[7:3]] <= avm_writedata;
      rdv   <= avm_read && !wr;
      rdata <= mem[avm_address[7:3]] ^
               ((corrupt && avm_address == 13'hA8) ? 64'h1 : 64'h0);
   end

   always @(negedge clk) begin
      if (reset_n && avm_write && !wr) begin
         chk++;
         if (exp_q.size() == 0) begin
            err++;
            $display("FAIL wr_unexpected act=%0h@%0h exp=none",
                     avm_writedata, avm_address);
         end else begin
            mon_e = exp_q.pop_front();
            if (avm_address !== mon_e.a || avm_writedata !== mon_e.d) begin
               err++;
               $display("FAIL wr_seq act=%0h@%0h exp=%0h@%0h",
                        avm_writedata, avm_address, mon_e.d, mon_e.a);
            end
         end
      end
   end

   task automatic chk_eq(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
      chk++;
      if (act !== exp) begin
         err++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   function automatic exp_t exp_k(input int k);
      exp_t e;
      case (k)
         0:  e = '{13'hC8, 64'h6};
         1:  e = '{13'h80, 64'(fmac)};
         2:  e = '{13'h88, 64'(fip)};
         3:  e = '{13'h90, 64'(fport)};
         4:  e = '{13'h98, 64'(fmask)};
         5:  e = '{13'hA0, 64'(hmac)};
         6:  e = '{13'hA8, 64'(hip)};
         7:  e = '{13'hB0, 64'(hport)};
         8:  e = '{13'hB8, 64'(payload)};
         9:  e = '{13'hC0, 64'(csum)};
         default: e = '{13'hC8, 64'h0};
      endcase
      return e;
   endfunction

   task automatic push_exp(input int n);
      for (int k = 0; k < n; k++) exp_q.push_back(exp_k(k));
   endtask

   // Runs one sequence; optional stall/abort on the first write to st_addr,
   // optional second start plus cfg change mid-run.
   task automatic run_seq(input logic [12:0] st_addr, input int st_len,
                          input bit mid_start, input bit abort,
                          output int n);
      int          left = 0;
      bit          stalling = 0;
      bit          armed = (st_len > 0);
      bit          aborted = 0;
      logic [12:0] ha = '0;
      logic [63:0] hd = '0;
      logic [47:0] sv_fmac = fmac;
      logic [31:0] sv_hip = hip;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      n = 0;
      while (!done && !error && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
         start = mid_start && n == 5;
         if (mid_start && n == 5) begin
            fmac = 48'hDEAD_BEEF_0000;
            hip  = 32'h0BAD_F00D;
         end
         if (n == 1) begin
            chk_eq("busy_early", busy, 1'b1);
            chk_eq("flags_clear", {done, error}, 2'b00);
         end
         if (stalling && !error) begin
            chk_eq("stall_stable", {avm_write, avm_address, avm_writedata},
                   {1'b1, ha, hd});
            left--;
            if (left == 0) begin
               wr = 1'b0;
               stalling = 0;
            end
         end else if (armed && avm_write && avm_address == st_addr) begin
            armed = 0;
            wr = 1'b1;
            if (abort) begin
               reset_n = 1'b0;
               @(posedge clk);
               #1;
               chk_eq("rst_avm", {avm_write, avm_read, avm_address,
                                  avm_writedata}, '0);
               chk_eq("rst_flags", {busy, done, error}, 3'b000);
               reset_n = 1'b1;
               wr = 1'b0;
               aborted = 1;
               break;
            end
            stalling = 1;
            left = st_len;
            ha = avm_address;
            hd = avm_writedata;
         end
      end
      wr = 1'b0;
      start = 1'b0;
      fmac = sv_fmac;
      hip = sv_hip;
      if (!aborted && !done && !error) begin
         err++;
         chk++;
         $display("FAIL run_budget act=%0d exp=<3000", n);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      start = 1'b0;
      wr = 1'b0;
      corrupt = 1'b0;
      fmac = 48'h0011_2233_4455;
      fip = 32'hC0A8_0102;
      fport = 16'h1234;
      fmask = 32'hFFFF_FF00;
      hmac = 48'hA0B1_C2D3_E4F5;
      hip = 32'hC0A8_0164;
      hport = 16'h5678;
      payload = 16'd1024;
      csum = 16'hB1E6;
      repeat (3) @(posedge clk);
      #1;
      chk_eq("reset_flags", {busy, done, error, err_step}, '0);
      chk_eq("reset_avm", {avm_write, avm_read, avm_address, avm_writedata}, '0);
      reset_n = 1'b1;
      repeat (2) @(posedge clk);

      push_exp(11);
      run_seq(13'h0, 0, 0, 0, lat);
      chk_eq("t1_done", {done, error, busy}, 3'b100);
      chk_eq("t1_lat", lat, LAT0);
      chk_eq("t1_q", exp_q.size(), 0);

      push_exp(11);
      run_seq(13'h90, 3, 0, 0, lat);
      chk_eq("t2_done", {done, error}, 2'b10);
      chk_eq("t2_lat", lat, LAT0 + 3);

      push_exp(11);
      run_seq(13'hC8, TMO - 1, 0, 0, lat);
      chk_eq("tmo_edge_done", {done, error}, 2'b10);
      chk_eq("tmo_edge_lat", lat, LAT0 + TMO - 1);

      push_exp(5);
      run_seq(13'hA0, 5000, 0, 0, lat);
      chk_eq("t3_err", {done, error, busy}, 3'b010);
      chk_eq("t3_step", err_step, 4);
      chk_eq("t3_lat", lat, STUCK4 + TMO);
      repeat (5) @(posedge clk);
      chk_eq("t3_no_release", exp_q.size(), 0);

      push_exp(11);
      run_seq(13'h0, 0, 1, 0, lat);
      chk_eq("t6_busy_start_done", {done, error}, 2'b10);
      chk_eq("t6_busy_start_lat", lat, LAT0);

      push_exp(7);
      run_seq(13'hB0, 1, 0, 1, lat);
      repeat (3) @(posedge clk);
      #1;
      chk_eq("t5_idle", {busy, done, error, avm_write}, 4'b0000);
      chk_eq("t5_q", exp_q.size(), 0);

      push_exp(11);
      run_seq(13'h0, 0, 0, 0, lat);
      chk_eq("t5_rerun_done", {done, error}, 2'b10);
      chk_eq("t5_rerun_lat", lat, LAT0);

      push_exp(11);
      run_seq(13'h0, 0, 0, 0, lat);
      chk_eq("t6_rerun_done", {done, error}, 2'b10);

`ifdef UOE_CSR_INIT_READBACK_EN
      corrupt = 1'b1;
      push_exp(7);
      run_seq(13'h0, 0, 0, 0, lat);
      corrupt = 1'b0;
      chk_eq("t4_err", {done, error}, 2'b01);
      chk_eq("t4_step", err_step, 5);
      repeat (5) @(posedge clk);
      chk_eq("t4_q", exp_q.size(), 0);
`endif

      repeat (5) @(posedge clk);
      chk_eq("final_q", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", chk, err);
      $finish;
   end

endmodule
